// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: the default NOP, the FSM
// state encoding and the layout of one queue entry.
package instruction_prefetch_unit_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h00000033;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } pf_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } pf_entry_t;

endpackage

// File: rtl/instruction_prefetch_unit_fifo.sv
// Prefetch queue. The pointers wrap naturally because DEPTH is a power of two.
// Flush empties the queue and outranks both push and pop. A push into a full
// queue is accepted only when a pop happens in the same cycle.
module prefetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             push_ok, pop_ok;

   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && ((count < CW'(DEPTH)) || pop_ok);
   assign rdata   = mem[rd_ptr];

   // storage array; not reset, since count alone decides what is valid
   always_ff @(posedge clk) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= wdata;
   end

   // pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit. It keeps at most one bus request outstanding and
// queues the returned instructions for decode. A redirect flushes the queue. If
// a request is still in flight when the redirect arrives, the unit parks the
// target in DRAIN until that response comes back and is thrown away.
module instruction_prefetch_unit #(
   parameter logic [31:0] BOOT_ADDRESS = 32'h00000000,
   parameter int          DEPTH        = 4,
   parameter logic [31:0] NOP_INSTR    = instruction_prefetch_unit_pkg::NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     ibus_req,
   output logic [31:0]              ibus_addr,
   input  logic                     ibus_ack,
   input  logic [31:0]              ibus_rdata,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   input  logic                     stall,
   output logic                     out_valid,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   output logic [$clog2(DEPTH):0]   out_count
);
   import instruction_prefetch_unit_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   pf_state_t       state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     pending_pc_q, pending_pc_d;
   logic [31:0]     target;
   logic [CW-1:0]   count;
   logic            push, pop;
   pf_entry_t       wr_entry, head;

   assign target = {redirect_pc[31:2], 2'b00};

   // the request depends only on registered state, so it stays stable until the ack
   assign ibus_req  = !reset && (((state_q == FETCH) && (count < CW'(DEPTH))) ||
                                 (state_q == DRAIN));
   assign ibus_addr = fetch_pc_q;

   assign out_valid = !reset && (count != '0);
   assign out_instr = out_valid ? head.instr : NOP_INSTR;
   assign out_pc    = out_valid ? head.pc    : 32'h0;
   assign out_count = reset ? '0 : count;

   // a redirect blocks both queue movements; the flush discards everything anyway
   assign pop      = out_valid && !stall && !redirect_valid;
   assign push     = (state_q == FETCH) && ibus_req && ibus_ack && !redirect_valid;
   assign wr_entry = '{pc: fetch_pc_q, instr: ibus_rdata};

   prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .count (count)
   );

   // next state and next fetch PC
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      pending_pc_d = pending_pc_q;
      case (state_q)
         FETCH: begin
            if (redirect_valid) begin
               if (ibus_req && !ibus_ack) begin
                  pending_pc_d = target;
                  state_d      = DRAIN;
               end else begin
                  fetch_pc_d = target;
               end
            end else if (ibus_req && ibus_ack) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
         DRAIN: begin
            if (ibus_ack) begin
               fetch_pc_d = redirect_valid ? target : pending_pc_q;
               state_d    = FETCH;
            end else if (redirect_valid) begin
               pending_pc_d = target;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   // FSM and PC registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FETCH;
         fetch_pc_q   <= BOOT_ADDRESS;
         pending_pc_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         pending_pc_q <= pending_pc_d;
      end
   end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed per-cycle vectors for the prefetch unit. A second instance, booting
// near the top of the address space, checks that the fetch PC wraps to zero.
module tb_instruction_prefetch_unit;
   localparam logic [31:0] N = 32'h00000033;

   logic        clk = 1'b0;
   logic        reset, ibus_ack, redirect_valid, stall;
   logic [31:0] ibus_rdata, redirect_pc;
   logic        ibus_req, out_valid;
   logic [31:0] ibus_addr, out_instr, out_pc;
   logic [2:0]  out_count;
   logic        b_req, b_valid;
   logic [31:0] b_addr, b_instr, b_pc;
   logic [2:0]  b_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instruction_prefetch_unit #(.BOOT_ADDRESS(32'h0), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
      .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .stall(stall), .out_valid(out_valid),
      .out_instr(out_instr), .out_pc(out_pc), .out_count(out_count));

   instruction_prefetch_unit #(.BOOT_ADDRESS(32'hFFFFFFF8), .DEPTH(4)) dut_wrap (
      .clk(clk), .reset(reset), .ibus_req(b_req), .ibus_addr(b_addr),
      .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .stall(stall), .out_valid(b_valid),
      .out_instr(b_instr), .out_pc(b_pc), .out_count(b_count));

   typedef struct {
      logic        rst, ack, rv, stl;
      logic [31:0] rdata, rpc;
      logic        e_req, chk_addr;
      logic [31:0] e_addr;
      logic        e_ov;
      logic [31:0] e_pc, e_instr;
      logic [2:0]  e_cnt;
      logic        b_chk;
      logic [31:0] b_pc;
   } vec_t;

   vec_t v[$];

   function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic rv,
                               logic [31:0] rpc, logic stl, logic e_req, logic ca,
                               logic [31:0] e_addr, logic e_ov, logic [31:0] e_pc,
                               logic [31:0] e_instr, logic [2:0] e_cnt, logic bc,
                               logic [31:0] bpc);
      vec_t r;
      r.rst = rst; r.ack = ack; r.rdata = rdata; r.rv = rv; r.rpc = rpc; r.stl = stl;
      r.e_req = e_req; r.chk_addr = ca; r.e_addr = e_addr; r.e_ov = e_ov;
      r.e_pc = e_pc; r.e_instr = e_instr; r.e_cnt = e_cnt; r.b_chk = bc; r.b_pc = bpc;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                        input logic rv, input logic [31:0] rpc, input logic stl);
      @(negedge clk);
      reset = rst; ibus_ack = ack; ibus_rdata = rdata;
      redirect_valid = rv; redirect_pc = rpc; stall = stl;
      #1;
   endtask

   initial begin
      reset = 1'b1; ibus_ack = 1'b0; ibus_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;

      // reset with a stray ack, then streaming with ack every cycle
      v.push_back(mk(1,1,0,0,0,0,           0,0,32'h0,   0,32'h0,N,0,           1,32'h0));
      v.push_back(mk(1,1,0,0,0,0,           0,1,32'h0,   0,32'h0,N,0,           1,32'h0));
      v.push_back(mk(0,1,32'h10000000,0,0,0, 1,1,32'h0,  0,32'h0,N,0,           1,32'h0));
      v.push_back(mk(0,1,32'h10000004,0,0,0, 1,1,32'h4,  1,32'h0,32'h10000000,1, 1,32'hFFFFFFF8));
      v.push_back(mk(0,1,32'h10000008,0,0,0, 1,1,32'h8,  1,32'h4,32'h10000004,1, 1,32'hFFFFFFFC));
      v.push_back(mk(0,1,32'h1000000C,0,0,0, 1,1,32'hC,  1,32'h8,32'h10000008,1, 1,32'h0));
      v.push_back(mk(0,1,32'h10000010,0,0,0, 1,1,32'h10, 1,32'hC,32'h1000000C,1, 1,32'h4));
      // fill under stall until the queue is full and the request drops
      v.push_back(mk(1,1,0,0,0,1,           0,0,32'h0,   0,32'h0,N,0,           0,0));
      v.push_back(mk(0,1,32'h10000000,0,0,1, 1,1,32'h0,  0,32'h0,N,0,           0,0));
      v.push_back(mk(0,1,32'h10000004,0,0,1, 1,1,32'h4,  1,32'h0,32'h10000000,1, 0,0));
      v.push_back(mk(0,1,32'h10000008,0,0,1, 1,1,32'h8,  1,32'h0,32'h10000000,2, 0,0));
      v.push_back(mk(0,1,32'h1000000C,0,0,1, 1,1,32'hC,  1,32'h0,32'h10000000,3, 0,0));
      v.push_back(mk(0,0,0,0,0,1,           0,1,32'h10,  1,32'h0,32'h10000000,4, 0,0));
      v.push_back(mk(0,0,0,0,0,1,           0,1,32'h10,  1,32'h0,32'h10000000,4, 0,0));
      v.push_back(mk(0,0,0,0,0,0,           0,1,32'h10,  1,32'h0,32'h10000000,4, 0,0));
      v.push_back(mk(0,1,32'h10000010,0,0,0, 1,1,32'h10, 1,32'h4,32'h10000004,3, 0,0));
      v.push_back(mk(0,0,0,0,0,1,           1,1,32'h14,  1,32'h8,32'h10000008,3, 0,0));
      // redirect while the request to 0x8 is in flight -> DRAIN
      v.push_back(mk(1,0,0,0,0,1,           0,0,32'h0,   0,32'h0,N,0,           0,0));
      v.push_back(mk(0,1,32'h10000000,0,0,1, 1,1,32'h0,  0,32'h0,N,0,           0,0));
      v.push_back(mk(0,1,32'h10000004,0,0,1, 1,1,32'h4,  1,32'h0,32'h10000000,1, 0,0));
      v.push_back(mk(0,0,0,0,0,1,           1,1,32'h8,   1,32'h0,32'h10000000,2, 0,0));
      v.push_back(mk(0,0,0,1,32'h200,1,     1,1,32'h8,   1,32'h0,32'h10000000,2, 0,0));
      v.push_back(mk(0,0,0,0,0,1,           1,1,32'h8,   0,32'h0,N,0,           0,0));
      v.push_back(mk(0,0,0,0,0,0,           1,1,32'h8,   0,32'h0,N,0,           0,0));
      v.push_back(mk(0,1,32'hDEADBEEF,0,0,0, 1,1,32'h8,  0,32'h0,N,0,           0,0));
      v.push_back(mk(0,0,0,0,0,0,           1,1,32'h200, 0,32'h0,N,0,           0,0));
      v.push_back(mk(0,1,32'h10000200,0,0,0, 1,1,32'h200,0,32'h0,N,0,           0,0));
      v.push_back(mk(0,0,0,0,0,0,           1,1,32'h204, 1,32'h200,32'h10000200,1, 0,0));
      v.push_back(mk(0,0,0,0,0,0,           1,1,32'h204, 0,32'h0,N,0,           0,0));
      // full queue, then pop + ack + redirect in one cycle; then DRAIN ack vs redirect
      v.push_back(mk(1,1,0,0,0,1,           0,0,32'h0,   0,32'h0,N,0,           0,0));
      v.push_back(mk(0,1,32'h10000000,0,0,1, 1,1,32'h0,  0,32'h0,N,0,           0,0));
      v.push_back(mk(0,1,32'h10000004,0,0,1, 1,1,32'h4,  1,32'h0,32'h10000000,1, 0,0));
      v.push_back(mk(0,1,32'h10000008,0,0,1, 1,1,32'h8,  1,32'h0,32'h10000000,2, 0,0));
      v.push_back(mk(0,1,32'h1000000C,0,0,1, 1,1,32'hC,  1,32'h0,32'h10000000,3, 0,0));
      v.push_back(mk(0,1,32'h99,1,32'h103,0, 0,1,32'h10, 1,32'h0,32'h10000000,4, 0,0));
      v.push_back(mk(0,0,0,0,0,0,           1,1,32'h100, 0,32'h0,N,0,           0,0));
      v.push_back(mk(0,0,0,1,32'h300,0,     1,1,32'h100, 0,32'h0,N,0,           0,0));
      v.push_back(mk(0,0,0,1,32'h503,0,     1,1,32'h100, 0,32'h0,N,0,           0,0));
      v.push_back(mk(0,1,32'h77,1,32'h407,0, 1,1,32'h100, 0,32'h0,N,0,          0,0));
      v.push_back(mk(0,0,0,0,0,0,           1,1,32'h404, 0,32'h0,N,0,           0,0));
      v.push_back(mk(0,1,32'h10000404,0,0,0, 1,1,32'h404,0,32'h0,N,0,           0,0));
      v.push_back(mk(0,0,0,0,0,0,           1,1,32'h408, 1,32'h404,32'h10000404,1, 0,0));

      foreach (v[i]) begin
         drive(v[i].rst, v[i].ack, v[i].rdata, v[i].rv, v[i].rpc, v[i].stl);
         chk("ibus_req", i, 32'(ibus_req), 32'(v[i].e_req));
         if (v[i].chk_addr) chk("ibus_addr", i, ibus_addr, v[i].e_addr);
         chk("out_valid", i, 32'(out_valid), 32'(v[i].e_ov));
         chk("out_pc", i, out_pc, v[i].e_pc);
         chk("out_instr", i, out_instr, v[i].e_instr);
         chk("out_count", i, 32'(out_count), 32'(v[i].e_cnt));
         if (v[i].b_chk) chk("wrap_out_pc", i, b_pc, v[i].b_pc);
      end

      // bounded fill: queue reaches DEPTH, request drops, address holds 0x10
      drive(1,0,0,0,0,1);
      drive(1,0,0,0,0,1);
      begin
         int cyc = 0;
         drive(0,1,32'h1,0,0,1);
         while (out_count != 3'd4 && cyc < 20) begin
            drive(0,1,32'h1,0,0,1);
            cyc++;
         end
         chk("fill_timeout", 100, 32'(out_count), 32'd4);
         chk("fill_req", 101, 32'(ibus_req), 32'd0);
         chk("fill_addr", 102, ibus_addr, 32'h10);
      end

      // reset while in DRAIN: no pending target survives
      drive(1,0,0,0,0,1);
      drive(0,0,0,0,0,1);
      drive(0,0,0,1,32'h200,1);
      drive(1,1,32'h5,0,0,1);
      drive(0,0,0,0,0,1);
      chk("rst_drain_req", 103, 32'(ibus_req), 32'd1);
      chk("rst_drain_addr", 104, ibus_addr, 32'h0);
      drive(0,1,32'h10000000,0,0,1);
      drive(0,0,0,0,0,1);
      chk("rst_drain_next", 105, ibus_addr, 32'h4);
      chk("rst_drain_pc", 106, out_pc, 32'h0);
      chk("rst_drain_cnt", 107, 32'(out_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
